// File: rtl/riscv_uop_pkg.sv
// Shared micro-op definitions for the write-back path.
//   NUM_WB_CH  : default number of execution channels merging into write-back
//   WB_XLEN    : default write-back data width
//   RD_W       : destination register index width
//   wb_entry_t : one buffered result, {rd, data}
package riscv_uop_pkg;

    localparam int unsigned NUM_WB_CH = 2;
    localparam int unsigned WB_XLEN   = 32;
    localparam int unsigned RD_W      = 5;

    typedef struct packed {
        logic [RD_W-1:0]    rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-channel result buffer: a DEPTH-entry FIFO of entry_t.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_flush    : empty the FIFO; concurrent push/pop are ignored
//   i_push     : write i_entry (ignored when full)
//   i_pop      : drop the head entry (ignored when empty)
//   o_full     : DEPTH entries held (registered occupancy only)
//   o_empty    : no entries held
//   o_head     : oldest entry, valid when !o_empty
module wb_fifo
    import riscv_uop_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_flush,
    input  logic   i_push,
    input  entry_t i_entry,
    input  logic   i_pop,
    output logic   o_full,
    output logic   o_empty,
    output entry_t o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the count, so the pointers can wrap naturally.
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push && !o_full && !i_flush;
        do_pop   = i_pop && !o_empty && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_entry;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers results from NUM_CH execution channels in
// per-channel FIFOs and retires at most one per cycle, round-robin.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : discard all buffered and incoming results
//   i_valid      : per-channel result valid
//   o_ready      : per-channel buffer not full
//   i_rd, i_data : per-channel destination register and result data
//   o_wb_en      : register-file write strobe (low for rd == 0)
//   o_wb_rd      : write-back destination register
//   o_wb_data    : write-back data
//   o_retire_cnt : wrapping count of retired results
module wb_arbiter
    import riscv_uop_pkg::*;
#(
    parameter int unsigned NUM_CH     = NUM_WB_CH,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = WB_XLEN
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_flush,
    input  logic [NUM_CH-1:0]              i_valid,
    output logic [NUM_CH-1:0]              o_ready,
    input  logic [NUM_CH-1:0][RD_W-1:0]    i_rd,
    input  logic [NUM_CH-1:0][XLEN-1:0]    i_data,
    output logic                           o_wb_en,
    output logic [RD_W-1:0]                o_wb_rd,
    output logic [XLEN-1:0]                o_wb_data,
    output logic [31:0]                    o_retire_cnt
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Same layout as wb_entry_t, but sized by this instance's XLEN.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    entry_t            head [NUM_CH];

    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;
    int unsigned       cand;
    entry_t            gnt_entry;

    logic              wb_en_q, wb_en_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = i_valid[c] && !full[c] && !i_flush;

        wb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (i_flush),
            .i_push  (push[c]),
            .i_entry ({i_rd[c], i_data[c]}),
            .i_pop   (pop[c]),
            .o_full  (full[c]),
            .o_empty (empty[c]),
            .o_head  (head[c])
        );
    end

    // Ready depends on registered occupancy only; a pop this cycle does not raise it.
    assign o_ready = ~full;

    // Round-robin: first non-empty channel starting after the last grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = (32'(last_grant_q) + i) % NUM_CH;
            if (!gnt_valid && !empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
        end
        if (i_flush) begin
            gnt_valid = 1'b0;
        end
    end

    always_comb begin
        pop = '0;
        if (gnt_valid) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    assign gnt_entry = head[gnt_idx];

    always_comb begin
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        retire_cnt_d = retire_cnt_q;
        last_grant_d = last_grant_q;
        if (gnt_valid) begin
            // x0 writes are retired but never strobe the register file.
            wb_en_d      = (gnt_entry.rd != '0);
            wb_rd_d      = gnt_entry.rd;
            wb_data_d    = gnt_entry.data;
            retire_cnt_d = retire_cnt_q + 32'd1;
            last_grant_d = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            retire_cnt_q <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            retire_cnt_q <= retire_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign o_wb_en      = wb_en_q;
    assign o_wb_rd      = wb_rd_q;
    assign o_wb_data    = wb_data_q;
    assign o_retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (NUM_CH=2, FIFO_DEPTH=2, XLEN=32).
// Expected write-backs are queued when stimulus is driven and compared
// by a monitor whenever o_wb_en is seen high.
module tb_wb_arbiter;

    localparam int NUM_CH     = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int XLEN       = 32;

    logic                        clk     = 1'b0;
    logic                        rst_n   = 1'b0;
    logic                        i_flush = 1'b0;
    logic [NUM_CH-1:0]           i_valid = '0;
    logic [NUM_CH-1:0]           o_ready;
    logic [NUM_CH-1:0][4:0]      i_rd    = '0;
    logic [NUM_CH-1:0][XLEN-1:0] i_data  = '0;
    logic                        o_wb_en;
    logic [4:0]                  o_wb_rd;
    logic [XLEN-1:0]             o_wb_data;
    logic [31:0]                 o_retire_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;
    logic [31:0] exp_retire;

    wb_arbiter #(
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .XLEN       (XLEN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_rd         (i_rd),
        .i_data       (i_data),
        .o_wb_en      (o_wb_en),
        .o_wb_rd      (o_wb_rd),
        .o_wb_data    (o_wb_data),
        .o_retire_cnt (o_retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] ent(input logic [4:0] rd, input logic [31:0] d);
        return {rd, d};
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && o_wb_en) begin
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 64'(o_wb_en), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wb_entry", 64'({o_wb_rd, o_wb_data}), 64'(mon_e));
            end
        end
    end

    // Flow-controlled producer: each channel offers consecutive data until accepted.
    task automatic stream(input int n0, input int n1, input logic [31:0] b0,
                          input logic [31:0] b1);
        int         s0 = 0;
        int         s1 = 0;
        int         budget = 0;
        logic [1:0] rdy;
        while ((s0 < n0 || s1 < n1) && budget < 200) begin
            i_valid[0] = (s0 < n0);
            i_valid[1] = (s1 < n1);
            i_rd[0]    = 5'd3;
            i_rd[1]    = 5'd4;
            i_data[0]  = b0 + 32'(s0);
            i_data[1]  = b1 + 32'(s1);
            rdy        = o_ready;
            @(negedge clk);
            if (i_valid[0] && rdy[0]) s0++;
            if (i_valid[1] && rdy[1]) s1++;
            budget++;
        end
        i_valid = '0;
        check_eq("stream_sent", 64'(s0 + s1), 64'(n0 + n1));
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        exp_retire = 32'd0;

        // Reset state
        #12;
        check_eq("rst_ready", 64'(o_ready), 64'd3);
        check_eq("rst_wb_en", 64'(o_wb_en), 64'd0);
        check_eq("rst_wb_rd", 64'(o_wb_rd), 64'd0);
        check_eq("rst_wb_data", 64'(o_wb_data), 64'd0);
        check_eq("rst_retire", 64'(o_retire_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, two-edge latency
        i_valid[0] = 1'b1;
        i_rd[0]    = 5'd5;
        i_data[0]  = 32'hDEAD_BEEF;
        exp_q.push_back(ent(5'd5, 32'hDEAD_BEEF));
        @(negedge clk);
        i_valid = '0;
        check_eq("lat_early", 64'(o_wb_en), 64'd0);
        @(negedge clk);
        check_eq("lat_wb_en", 64'(o_wb_en), 64'd1);
        exp_retire = 32'd1;
        check_eq("lat_retire", 64'(o_retire_cnt), 64'(exp_retire));
        drain("drain_single");

        // Both channels streaming; ch0 was granted last so ch1 leads
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(ent(5'd4, 32'h200 + 32'(n)));
            exp_q.push_back(ent(5'd3, 32'h100 + 32'(n)));
        end
        stream(4, 4, 32'h100, 32'h200);
        drain("drain_alt");
        exp_retire += 32'd8;
        check_eq("alt_retire", 64'(o_retire_cnt), 64'(exp_retire));

        // rd == 0 on ch1: retired silently (also leaves ch1 as last grant)
        i_valid[1] = 1'b1;
        i_rd[1]    = 5'd0;
        i_data[1]  = 32'h55;
        @(negedge clk);
        i_valid = '0;
        @(negedge clk);
        check_eq("rd0_wb_en", 64'(o_wb_en), 64'd0);
        exp_retire += 32'd1;
        check_eq("rd0_retire", 64'(o_retire_cnt), 64'(exp_retire));
        repeat (2) @(negedge clk);

        // Backpressure on ch1: full after two accepts, third waits for a pop
        exp_q.push_back(ent(5'd6, 32'h300));
        exp_q.push_back(ent(5'd7, 32'h400));
        exp_q.push_back(ent(5'd6, 32'h301));
        exp_q.push_back(ent(5'd7, 32'h401));
        exp_q.push_back(ent(5'd7, 32'h402));
        i_valid = 2'b11;
        i_rd[0] = 5'd6;
        i_rd[1] = 5'd7;
        i_data[0] = 32'h300;
        i_data[1] = 32'h400;
        @(negedge clk);
        i_data[0] = 32'h301;
        i_data[1] = 32'h401;
        @(negedge clk);
        check_eq("bp_ready1_full", 64'(o_ready[1]), 64'd0);
        check_eq("bp_ready0", 64'(o_ready[0]), 64'd1);
        i_valid[0] = 1'b0;
        i_data[1]  = 32'h402;
        @(negedge clk);
        check_eq("bp_ready1_after_pop", 64'(o_ready[1]), 64'd1);
        @(negedge clk);
        i_valid = '0;
        drain("drain_bp");
        exp_retire += 32'd5;
        check_eq("bp_retire", 64'(o_retire_cnt), 64'(exp_retire));

        // Flush with a simultaneous push
        exp_q.push_back(ent(5'd8, 32'h500));
        i_valid = 2'b11;
        i_rd[0] = 5'd8;
        i_rd[1] = 5'd9;
        i_data[0] = 32'h500;
        i_data[1] = 32'h600;
        @(negedge clk);
        i_data[0] = 32'h501;
        i_data[1] = 32'h601;
        @(negedge clk);
        i_flush   = 1'b1;
        i_data[0] = 32'h502;
        i_data[1] = 32'h602;
        @(negedge clk);
        i_flush = 1'b0;
        i_valid = '0;
        exp_retire += 32'd1;
        check_eq("flush_wb_en", 64'(o_wb_en), 64'd0);
        check_eq("flush_ready", 64'(o_ready), 64'd3);
        check_eq("flush_retire", 64'(o_retire_cnt), 64'(exp_retire));
        repeat (4) @(negedge clk);
        check_eq("flush_retire_late", 64'(o_retire_cnt), 64'(exp_retire));
        check_eq("flush_queue", 64'(exp_q.size()), 64'd0);

        // Retire counter wrap
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_cnt_q;
        #1;
        check_eq("wrap_preset", 64'(o_retire_cnt), 64'hFFFF_FFFF);
        exp_q.push_back(ent(5'd10, 32'hAAAA_5555));
        i_valid[0] = 1'b1;
        i_rd[0]    = 5'd10;
        i_data[0]  = 32'hAAAA_5555;
        @(negedge clk);
        i_valid = '0;
        @(negedge clk);
        check_eq("wrap_retire", 64'(o_retire_cnt), 64'd0);

        // Asynchronous reset in the middle of a burst
        i_valid = 2'b11;
        i_rd[0] = 5'd12;
        i_rd[1] = 5'd13;
        i_data[0] = 32'h700;
        i_data[1] = 32'h800;
        @(negedge clk);
        i_valid = '0;
        @(posedge clk);
        #1;
        check_eq("burst_wb_en", 64'(o_wb_en), 64'd1);
        check_eq("burst_retire", 64'(o_retire_cnt), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wb_en", 64'(o_wb_en), 64'd0);
        check_eq("arst_wb_rd", 64'(o_wb_rd), 64'd0);
        check_eq("arst_wb_data", 64'(o_wb_data), 64'd0);
        check_eq("arst_retire", 64'(o_retire_cnt), 64'd0);
        check_eq("arst_ready", 64'(o_ready), 64'd3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("arst_no_leftover", 64'(o_retire_cnt), 64'd0);
        check_eq("final_queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of execution channels (ALU, LSU, ...) merging into write-back; legal range 1..8.
REQ-002 Parameter FIFO_DEPTH, default 2, per-channel buffer entries; power of two, at least 2.
REQ-003 Parameter XLEN, default 32, write-back data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_flush  input  1  discard all buffered and incoming results.
REQ-007 i_valid  input  NUM_CH  per-channel result valid.
REQ-008 o_ready  output  NUM_CH  per-channel buffer not full.
REQ-009 i_rd  input  NUM_CH x 5  per-channel destination register.
REQ-010 i_data  input  NUM_CH x XLEN  per-channel result data.
REQ-011 o_wb_en  output  1  register-file write strobe.
REQ-012 o_wb_rd  output  5  write-back destination register.
REQ-013 o_wb_data  output  XLEN  write-back data.
REQ-014 o_retire_cnt  output  32  count of retired results.

Function
REQ-015 Channel c SHALL accept an entry on an edge where i_valid[c] and o_ready[c] are both high and i_flush is low.
REQ-016 o_ready[c] SHALL be high exactly when channel c's FIFO holds fewer than FIFO_DEPTH entries.
REQ-017 o_ready[c] SHALL derive from registered occupancy only; a same-cycle pop SHALL NOT raise it.
REQ-018 Each channel FIFO SHALL preserve arrival order; entries are {rd, data}.
REQ-019 Each cycle, the arbiter SHALL grant at most one non-empty channel by round-robin.
REQ-020 The round-robin search SHALL start at (last_grant+1) mod NUM_CH; last_grant SHALL update only on a grant.
REQ-021 The granted head SHALL be popped on the edge, and o_wb_en/o_wb_rd/o_wb_data SHALL be registered on that same edge.
REQ-022 Latency: an entry accepted on edge k into an empty, uncontended FIFO SHALL appear on the outputs after edge k+1.
REQ-023 A popped entry with rd==0 SHALL drive o_wb_en low while still being counted as retired.
REQ-024 With no grant, o_wb_en SHALL be 0 the next cycle, and o_wb_rd/o_wb_data SHALL hold their previous values.
REQ-025 o_retire_cnt SHALL increment by 1 per pop and wrap from 0xFFFFFFFF to 0.
REQ-026 When i_flush is high on an edge, all FIFOs SHALL empty, incoming entries SHALL be dropped, no pop SHALL occur, and o_wb_en SHALL be 0 the next cycle.
REQ-027 A flush SHALL leave o_retire_cnt and last_grant unchanged.
REQ-028 Each FIFO's read and write pointers SHALL wrap modulo FIFO_DEPTH; the full/empty distinction SHALL use a count or an extra pointer bit.

Reset
REQ-029 While rst_n is low, all FIFOs SHALL be empty, o_ready SHALL be all ones, and o_wb_en, o_wb_rd and o_wb_data SHALL be 0.
REQ-030 While rst_n is low, o_retire_cnt SHALL be 0 and last_grant SHALL be NUM_CH-1, so that channel 0 has first priority.
REQ-031 Reset asserted mid-operation SHALL discard every buffered entry immediately, without waiting for a clock edge.

Structure
REQ-032 riscv_uop_pkg SHALL hold the wb_entry_t typedef {rd[4:0], data[XLEN-1:0]} and the NUM_WB_CH default constant.
REQ-033 The per-channel buffer SHALL be a sub-module wb_fifo (params DEPTH, entry type), instantiated NUM_CH times via generate.
REQ-034 Round-robin selection SHALL be combinational logic in wb_arbiter; no other sub-modules.

Verification
REQ-035 Reset, then a single push: ch0 valid, rd=5, data=0xDEADBEEF at edge 1 -> o_wb_en=1, rd=5, data=0xDEADBEEF after edge 2; o_retire_cnt=1.
REQ-036 Both channels valid every cycle, ch0 data=0x100+n, ch1 data=0x200+n -> outputs alternate ch0,ch1,ch0,...; per-channel order is preserved.
REQ-037 ch1 held valid while write-back is monopolised, with FIFO_DEPTH=2 -> o_ready[1] drops after 2 accepts; a third push is not accepted until a pop is registered.
REQ-038 Push rd=0, data=0x55 -> o_wb_en stays 0 and o_retire_cnt increments by 1.
REQ-039 Fill both FIFOs, then pulse i_flush with a simultaneous push -> no write-back follows, o_ready is all ones, and o_retire_cnt is unchanged.
REQ-040 Force o_retire_cnt to 0xFFFFFFFF via a long run, retire one more -> o_retire_cnt=0; assert rst_n low mid-burst -> outputs are 0 asynchronously.
